// File: rtl/rapids_datapath_if.sv
// Control/address fields from decode into the datapath and the two results back.
// Single-cycle, no handshake: every field is sampled combinationally each cycle.
interface rapids_datapath_if #(
  parameter int WIDTH = 32
);
  logic [2:0]       op;
  logic             form;
  logic [1:0]       vec;
  logic [3:0]       A;
  logic [3:0]       B;
  logic [3:0]       C;
  logic [3:0]       D;
  logic [3:0]       zero_reg;
  logic [3:0]       Y1;
  logic [3:0]       Y2;
  logic [1:0]       write;
  logic [WIDTH-1:0] res1;
  logic [WIDTH-1:0] res2;

  modport master (
    output op, form, vec, A, B, C, D, zero_reg, Y1, Y2, write,
    input  res1, res2
  );

  modport slave (
    input  op, form, vec, A, B, C, D, zero_reg, Y1, Y2, write,
    output res1, res2
  );
endinterface

// File: rtl/rapids_datapath.sv
// Two-result SIMD datapath: 16-entry register file, 4 read / 2 write ports, lane-split ALU.
// Optional macro DATAPATH_MUL_EN turns op 7 into a per-lane multiply (otherwise op 7 passes x).
module rapids_datapath #(
  parameter int WIDTH = 32
) (
  input logic              clk,
  input logic              rst_n,
  rapids_datapath_if.slave dp
);

  logic [WIDTH-1:0] rf [16];
  logic [WIDTH-1:0] opa, opb, opc, opd;
  logic [WIDTH-1:0] r1, r2;

  // One lane of width lw; operands arrive zero-extended, result is trimmed to lw bits
  // so nothing carried or shifted past the lane survives.
  function automatic logic [WIDTH-1:0] f_lane(input logic [2:0] op,
                                               input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y,
                                               input int lw);
    logic [WIDTH-1:0] ones;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] amt;
    logic [WIDTH-1:0] r;
    ones = '1;
    mask = ones >> (WIDTH - lw);
    amt  = y % WIDTH'(lw);
    case (op)
      3'd0:    r = x + y;
      3'd1:    r = x - y;
      3'd2:    r = x & y;
      3'd3:    r = x | y;
      3'd4:    r = x ^ y;
      3'd5:    r = x << amt;
      3'd6:    r = x >> amt;
`ifdef DATAPATH_MUL_EN
      default: r = x * y;
`else
      default: r = x;
`endif
    endcase
    return r & mask;
  endfunction

  function automatic logic [WIDTH-1:0] alu(input logic [2:0] op,
                                            input logic [1:0] vec,
                                            input logic [WIDTH-1:0] x,
                                            input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] r;
    r = '0;
    case (vec)
      2'd1: begin
        for (int i = 0; i < WIDTH / 16; i++)
          r[i*16 +: 16] = 16'(f_lane(op, WIDTH'(x[i*16 +: 16]), WIDTH'(y[i*16 +: 16]), 16));
      end
      2'd2: begin
        for (int i = 0; i < WIDTH / 8; i++)
          r[i*8 +: 8] = 8'(f_lane(op, WIDTH'(x[i*8 +: 8]), WIDTH'(y[i*8 +: 8]), 8));
      end
      // vec 3 is reserved and treated as scalar
      default: r = f_lane(op, x, y, WIDTH);
    endcase
    return r;
  endfunction

  always_comb begin
    opa = dp.zero_reg[0] ? '0 : rf[dp.A];
    opb = dp.zero_reg[1] ? '0 : rf[dp.B];
    opc = dp.zero_reg[2] ? '0 : rf[dp.C];
    opd = dp.zero_reg[3] ? '0 : rf[dp.D];
  end

  // Chained form feeds R1 into the second ALU in place of c.
  always_comb begin
    r1 = alu(dp.op, dp.vec, opa, opb);
    r2 = alu(dp.op, dp.vec, dp.form ? r1 : opc, opd);
  end

  assign dp.res1 = r1;
  assign dp.res2 = r2;

  // Port Y2 is assigned last so it wins when both ports target the same register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) rf[i] <= WIDTH'(i);
    end else begin
      if (dp.write[0]) rf[dp.Y1] <= r1;
      if (dp.write[1]) rf[dp.Y2] <= r2;
    end
  end

endmodule

// File: tb/tb_rapids_datapath.sv
// Self-checking bench for rapids_datapath: typed per-lane reference model, scoreboard queue.
// Honours DATAPATH_MUL_EN in the model so it can run against either build.
module tb_rapids_datapath;
  localparam int W = 32;

  logic clk;
  logic rst_n;
  rapids_datapath_if #(.WIDTH(W)) dp ();

  rapids_datapath #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .dp    (dp)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] m_rf [16];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic m_reset();
    for (int i = 0; i < 16; i++) m_rf[i] = W'(i);
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, expv);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] m_f8(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y);
    case (op)
      3'd0: return x + y;
      3'd1: return x - y;
      3'd2: return x & y;
      3'd3: return x | y;
      3'd4: return x ^ y;
      3'd5: return x << y[2:0];
      3'd6: return x >> y[2:0];
`ifdef DATAPATH_MUL_EN
      default: return x * y;
`else
      default: return x;
`endif
    endcase
  endfunction

  function automatic logic [15:0] m_f16(input logic [2:0] op, input logic [15:0] x, input logic [15:0] y);
    case (op)
      3'd0: return x + y;
      3'd1: return x - y;
      3'd2: return x & y;
      3'd3: return x | y;
      3'd4: return x ^ y;
      3'd5: return x << y[3:0];
      3'd6: return x >> y[3:0];
`ifdef DATAPATH_MUL_EN
      default: return x * y;
`else
      default: return x;
`endif
    endcase
  endfunction

  function automatic logic [31:0] m_f32(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    case (op)
      3'd0: return x + y;
      3'd1: return x - y;
      3'd2: return x & y;
      3'd3: return x | y;
      3'd4: return x ^ y;
      3'd5: return x << y[4:0];
      3'd6: return x >> y[4:0];
`ifdef DATAPATH_MUL_EN
      default: return x * y;
`else
      default: return x;
`endif
    endcase
  endfunction

  function automatic logic [31:0] m_alu(input logic [2:0] op, input logic [1:0] vec,
                                        input logic [31:0] x, input logic [31:0] y);
    logic [31:0] r;
    r = '0;
    case (vec)
      2'd1: for (int i = 0; i < 2; i++) r[i*16 +: 16] = m_f16(op, x[i*16 +: 16], y[i*16 +: 16]);
      2'd2: for (int i = 0; i < 4; i++) r[i*8 +: 8] = m_f8(op, x[i*8 +: 8], y[i*8 +: 8]);
      default: r = m_f32(op, x, y);
    endcase
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  // Drives one operation after a rising edge, checks results at the falling edge,
  // and commits the model writes that the next rising edge performs.
  task automatic do_op(input string tag, input logic [2:0] op, input logic form, input logic [1:0] vec,
                       input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d,
                       input logic [3:0] zr, input logic [3:0] y1, input logic [3:0] y2,
                       input logic [1:0] wr, output logic [W-1:0] got1, output logic [W-1:0] got2);
    logic [W-1:0] va, vb, vc, vd, e1, e2;
    @(posedge clk);
    #1;
    dp.op = op; dp.form = form; dp.vec = vec;
    dp.A = a; dp.B = b; dp.C = c; dp.D = d;
    dp.zero_reg = zr; dp.Y1 = y1; dp.Y2 = y2; dp.write = wr;
    va = zr[0] ? '0 : m_rf[a];
    vb = zr[1] ? '0 : m_rf[b];
    vc = zr[2] ? '0 : m_rf[c];
    vd = zr[3] ? '0 : m_rf[d];
    e1 = m_alu(op, vec, va, vb);
    e2 = m_alu(op, vec, form ? e1 : vc, vd);
    exp_q.push_back(e1);
    exp_q.push_back(e2);
    @(negedge clk);
    got1 = dp.res1;
    got2 = dp.res2;
    check({tag, "_res1"}, got1, exp_q.pop_front());
    check({tag, "_res2"}, got2, exp_q.pop_front());
    if (wr[0]) m_rf[y1] = e1;
    if (wr[1]) m_rf[y2] = e2;
  endtask

  // Reads one register through port A (b, c, d masked, OR with zero) against a fixed value.
  task automatic read_reg(input string tag, input logic [3:0] idx, input logic [W-1:0] expv);
    logic [W-1:0] g1, g2;
    do_op(tag, 3'd3, 1'b0, 2'd0, idx, 4'd0, 4'd0, 4'd0, 4'b1110, 4'd0, 4'd0, 2'b00, g1, g2);
    check({tag, "_const"}, g1, expv);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] g1, g2;
    rst_n = 1'b0;
    dp.op = '0; dp.form = 1'b0; dp.vec = '0;
    dp.A = '0; dp.B = '0; dp.C = '0; dp.D = '0;
    dp.zero_reg = '0; dp.Y1 = '0; dp.Y2 = '0; dp.write = '0;
    m_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset contents: 3 + 5
    do_op("rst_add", 3'd0, 1'b0, 2'd0, 4'd3, 4'd5, 4'd0, 4'd0, 4'b0000, 4'd0, 4'd0, 2'b00, g1, g2);
    check("rst_add_const", g1, 32'd8);
    read_reg("rst_r3", 4'd3, 32'd3);
    read_reg("rst_r5", 4'd5, 32'd5);

    // Write then read-back: 9 - 4 into rf[2]
    do_op("sub_wr", 3'd1, 1'b0, 2'd0, 4'd9, 4'd4, 4'd0, 4'd0, 4'b0000, 4'd2, 4'd0, 2'b01, g1, g2);
    check("sub_wr_const", g1, 32'd5);
    do_op("op7_rd", 3'd7, 1'b0, 2'd0, 4'd2, 4'd0, 4'd0, 4'd0, 4'b0010, 4'd0, 4'd0, 2'b00, g1, g2);
`ifdef DATAPATH_MUL_EN
    check("op7_rd_const", g1, 32'd0);
`else
    check("op7_rd_const", g1, 32'd5);
`endif
    read_reg("rb_r2", 4'd2, 32'd5);

    // Build 0xFF in rf[11]: (15 << 4) | 15
    do_op("shl_wr", 3'd5, 1'b0, 2'd0, 4'd15, 4'd4, 4'd0, 4'd0, 4'b0000, 4'd11, 4'd0, 2'b01, g1, g2);
    do_op("or_wr", 3'd3, 1'b0, 2'd0, 4'd11, 4'd15, 4'd0, 4'd0, 4'b0000, 4'd11, 4'd0, 2'b01, g1, g2);
    read_reg("rb_r11", 4'd11, 32'h0000_00FF);

    // Lane isolation: 0xFF + 1 per lane width, and a byte borrow
    do_op("lane8_add", 3'd0, 1'b0, 2'd2, 4'd11, 4'd1, 4'd0, 4'd0, 4'b0000, 4'd0, 4'd0, 2'b00, g1, g2);
    check("lane8_add_const", g1, 32'h0000_0000);
    do_op("lane32_add", 3'd0, 1'b0, 2'd0, 4'd11, 4'd1, 4'd0, 4'd0, 4'b0000, 4'd0, 4'd0, 2'b00, g1, g2);
    check("lane32_add_const", g1, 32'h0000_0100);
    do_op("lane16_add", 3'd0, 1'b0, 2'd1, 4'd11, 4'd1, 4'd0, 4'd0, 4'b0000, 4'd0, 4'd0, 2'b00, g1, g2);
    check("lane16_add_const", g1, 32'h0000_0100);
    do_op("lane8_sub", 3'd1, 1'b0, 2'd2, 4'd0, 4'd1, 4'd0, 4'd0, 4'b0000, 4'd0, 4'd0, 2'b00, g1, g2);
    check("lane8_sub_const", g1, 32'h0000_00FF);
    do_op("lane32_sub", 3'd1, 1'b0, 2'd3, 4'd0, 4'd1, 4'd0, 4'd0, 4'b0000, 4'd0, 4'd0, 2'b00, g1, g2);
    check("lane32_sub_const", g1, 32'hFFFF_FFFF);

    // Chained form with b masked, C ignored
    do_op("chain", 3'd0, 1'b1, 2'd0, 4'd3, 4'd4, 4'd9, 4'd5, 4'b0010, 4'd0, 4'd0, 2'b00, g1, g2);
    check("chain_r1_const", g1, 32'd3);
    check("chain_r2_const", g2, 32'd8);

    // Write conflict: R1 = 5+3, R2 = 4+6 both to rf[7]
    do_op("conflict", 3'd0, 1'b0, 2'd0, 4'd2, 4'd3, 4'd4, 4'd6, 4'b0000, 4'd7, 4'd7, 2'b11, g1, g2);
    read_reg("conflict_r7", 4'd7, 32'd10);

    // Random operations against the model
    for (int n = 0; n < 200; n++) begin
      do_op("rand", 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15) & 4'b0101),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), g1, g2);
    end

    // Asynchronous reset between edges; reads must show index values right away
    #1;
    dp.op = 3'd3; dp.form = 1'b0; dp.vec = 2'd0; dp.zero_reg = 4'b1110;
    dp.write = 2'b11; dp.Y1 = 4'd5; dp.Y2 = 4'd6;
    rst_n = 1'b0;
    m_reset();
    for (int i = 0; i < 16; i++) begin
      dp.A = 4'(i);
      #1;
      check("async_rst", dp.res1, W'(i));
    end
    // Writes stay blocked across a rising edge while reset is held
    dp.op = 3'd0; dp.zero_reg = 4'b0000; dp.A = 4'd15; dp.B = 4'd15;
    @(posedge clk);
    @(negedge clk);
    dp.write = 2'b00;
    rst_n = 1'b1;
    read_reg("blk_r5", 4'd5, 32'd5);
    read_reg("blk_r6", 4'd6, 32'd6);

    // Writes resume after release
    do_op("post_wr", 3'd4, 1'b0, 2'd0, 4'd12, 4'd10, 4'd0, 4'd0, 4'b0000, 4'd4, 4'd0, 2'b01, g1, g2);
    read_reg("post_r4", 4'd4, 32'd6);

    check("sb_empty", W'(exp_q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
